// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each accepted request occupies one ACCESS cycle; completions are reported one cycle later.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH      = 16,
  parameter int USED_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH         = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req0_i,
  input  logic                     we0_i,
  input  logic [ADDRESS_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0]    wdata0_i,
  input  logic                     req1_i,
  input  logic                     we1_i,
  input  logic [ADDRESS_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0]    wdata1_i,
  output logic                     gnt0_o,
  output logic                     gnt1_o,
  output logic                     rvalid0_o,
  output logic                     rvalid1_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     err_o,
  output logic [ADDRESS_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0]    mem_wd_o,
  output logic                     mem_wen_o,
  input  logic [DATA_WIDTH-1:0]    mem_rd_i
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_last;
  logic                     r_owner;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_rvalid0;
  logic                     r_rvalid1;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_err;
  logic                     w_pick1;
  logic                     w_err;

  // Port 1 wins when it is the only requester, or on contention when port 0 was served last.
  assign w_pick1 = req1_i && (!req0_i || !r_last);
  assign w_err   = |(r_addr >> USED_ADDRESS_WIDTH);

  always_comb begin
    w_state_nxt = r_state;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    mem_wen_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst_i && (req0_i || req1_i)) begin
          gnt0_o      = !w_pick1;
          gnt1_o      = w_pick1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_wen_o   = r_we && !w_err && !rst_i;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (r_state == IDLE && (gnt0_o || gnt1_o)) begin
        r_owner <= w_pick1;
        r_last  <= w_pick1;
        r_we    <= w_pick1 ? we1_i    : we0_i;
        r_addr  <= w_pick1 ? addr1_i  : addr0_i;
        r_wdata <= w_pick1 ? wdata1_i : wdata0_i;
      end
      if (r_state == ACCESS) begin
        // Writes and out-of-range accesses report zero data.
        r_rdata   <= (r_we || w_err) ? '0 : mem_rd_i;
        r_err     <= w_err;
        r_rvalid0 <= !r_owner;
        r_rvalid1 <= r_owner;
      end
    end
  end

  assign rvalid0_o = r_rvalid0;
  assign rvalid1_o = r_rvalid1;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;
  assign mem_a_o   = r_addr;
  assign mem_wd_o  = r_wdata;

endmodule
